seg7_scan_display: RTL and testbench
====================================

// Module: seg7_scan_display
// PURPOSE
//   Board-level display stage downstream of TOP_RIJ_CPU. Consumes the CPU observation outputs (F, M_R_Data, PC, ZF, OF).
//   Shows one selected 32-bit word as 8 hex digits on a multiplexed 8-digit seven-segment display, and drives two flag LEDs.
//   A freeze input holds the displayed word while the CPU keeps running.
// PARAMETERS
//   SCAN_DIV        100000  clk_100MHz cycles per digit slot (1 kHz digit rate); legal range >= 2
//   SEG_ACTIVE_LOW  1       1: an/seg active-low (board default); 0: active-high
// PORTS
//   clk_100MHz  in   1   board clock; the only clock
//   rst         in   1   synchronous, active-high reset
//   F           in   32  ALU result from CPU
//   M_R_Data    in   32  data-memory read data from CPU
//   PC          in   32  program counter from CPU
//   ZF          in   1   zero flag
//   OF          in   1   overflow flag
//   sel         in   2   word select: 00 F, 01 M_R_Data, 10 PC, 11 {30'b0,OF,ZF}
//   freeze      in   1   1 = hold the displayed word
//   an          out  8   digit enables, one-hot; an[i] drives digit i, digit 0 = LS nibble
//   seg         out  8   {dp,g,f,e,d,c,b,a}
//   led         out  2   {OF,ZF} registered
// BEHAVIOUR
//   - Outputs below are given in active-high terms. SEG_ACTIVE_LOW=1 inverts an and seg bitwise.
//   - Reset (sampled on clk_100MHz edge while rst=1): prescaler cnt=0, digit index d=0, disp_val=0.
//     an=all off, seg=all off, led=00. All outputs are registered.
//   - Prescaler: cnt counts 0..SCAN_DIV-1. tick=1 when cnt==SCAN_DIV-1; on tick cnt wraps to 0.
//   - Digit index: d advances on tick, wraps 7->0. Each digit is lit exactly SCAN_DIV cycles.
//   - Snapshot: disp_val <= mux(sel) every cycle while freeze=0; holds while freeze=1.
//     Source-to-disp_val latency is 1 cycle.
//   - A sel or source change while freeze=1 is ignored; it is loaded the first cycle after freeze falls.
//   - Output register (1 cycle after d/disp_val):
//     an = one-hot(d);
//     seg[6:0] = hexdec(disp_val[4d+3:4d]);
//     seg[7] (dp) = freeze && d==0.
//   - First cycle after reset release: an=digit 0 on, showing digit 0 of disp_val=0.
//   - hexdec (gfedcba): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
//   - led <= {OF,ZF} each cycle; 1-cycle latency; not affected by freeze.
//   - Reset mid-scan: next edge forces the reset values. Scanning restarts at d=0 with a full SCAN_DIV slot.
//   - Simultaneous freeze rise and source change: freeze wins; the pre-edge disp_val is held.
// CONFIGURATION
//   LZ_BLANK_EN defined: leading-zero blanking.
//     - Digit i is forced off (an bit inactive, seg all off) if i>0 and disp_val[31:4i]==0.
//     - Digit 0 is always shown. Scan timing is unchanged; blanked slots stay dark.
//   LZ_BLANK_EN undefined: all 8 digits shown every scan, including leading zeros.
// TESTING
//   1. rst=1 for 3 cycles -> an=8'hFF, seg=8'hFF, led=00 (active-low).
//      Release, all sources 0 -> next cycle an=8'hFE, seg=8'hC0.
//   2. SCAN_DIV=4, sel=00, F=32'h1234ABCD -> digit 0: an=FE, seg=8'hA1 ('d').
//      Digit advances every 4 cycles; digit 7: an=7F, seg=8'hF9 ('1'). Digit 0 returns after 32 cycles.
//   3. sel=10, PC=32'h40, freeze=1, then PC=32'h44 -> digit 1 still shows '4', digit 0 shows '0', dp on digit 0.
//      freeze=0 -> digit 0 shows '4' from the next frame, dp off.
//   4. ZF=1, OF=0 -> led=2'b01 one cycle later. OF=1 -> led=2'b11. Unchanged while freeze=1.
//   5. rst pulsed while d=5 -> next cycle an=8'hFF. After release: digit 0 lit for a full SCAN_DIV cycles, then digit 1.
//   6. LZ_BLANK_EN defined, F=32'h40 -> only an[1:0] ever asserted.
//      F=0 -> only an[0], seg=8'hC0. Macro undefined -> all 8 digits asserted in turn.

Source files
------------

// File: rtl/seg7_scan_display.sv
// seg7_scan_display: shows one selectable 32-bit CPU observation word as 8 hex
// digits on a multiplexed seven-segment display and mirrors ZF/OF on two LEDs.
// Optional feature: define LZ_BLANK_EN to blank leading-zero digits (digit 0 is
// always shown). Without the macro all 8 digits are lit in turn every scan.
module seg7_scan_display #(
  parameter int unsigned SCAN_DIV       = 100000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk_100MHz,
  input  logic        rst,
  input  logic [31:0] F,
  input  logic [31:0] M_R_Data,
  input  logic [31:0] PC,
  input  logic        ZF,
  input  logic        OF,
  input  logic [1:0]  sel,
  input  logic        freeze,
  output logic [7:0]  an,
  output logic [7:0]  seg,
  output logic [1:0]  led
);

  localparam int unsigned CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [7:0] POL = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

  logic [CNT_W-1:0] cnt;
  logic [2:0]       d;
  logic [31:0]      disp_val;
  logic             tick_c;
  logic [31:0]      src_c;
  logic [3:0]       nib_c;
  logic             blank_c;
  logic [7:0]       an_hi_c;
  logic [7:0]       seg_hi_c;

  // Hex digit to gfedcba segment pattern (active-high).
  function automatic logic [6:0] hexdec(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  assign tick_c = (cnt == CNT_LAST);

  // Prescaler: one tick per digit slot.
  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Digit index advances once per slot, wrapping 7 -> 0.
  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      d <= 3'd0;
    end else if (tick_c) begin
      d <= d + 3'd1;
    end
  end

  // Source word select.
  always_comb begin
    src_c = F;
    case (sel)
      2'b00:   src_c = F;
      2'b01:   src_c = M_R_Data;
      2'b10:   src_c = PC;
      default: src_c = {30'd0, OF, ZF};
    endcase
  end

  // Snapshot register; freeze holds the displayed word.
  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      disp_val <= 32'd0;
    end else if (!freeze) begin
      disp_val <= src_c;
    end
  end

  // Current digit decode, with optional leading-zero blanking.
  always_comb begin
    nib_c   = disp_val[{d, 2'b00} +: 4];
    blank_c = 1'b0;
`ifdef LZ_BLANK_EN
    blank_c = (d != 3'd0) && ((disp_val >> {d, 2'b00}) == 32'd0);
`else
    blank_c = 1'b0;
`endif
    an_hi_c  = 8'd0;
    seg_hi_c = 8'd0;
    if (!blank_c) begin
      an_hi_c  = 8'd1 << d;
      seg_hi_c = {freeze && (d == 3'd0), hexdec(nib_c)};
    end
  end

  // Registered outputs in board polarity.
  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      an  <= POL;
      seg <= POL;
      led <= 2'b00;
    end else begin
      an  <= an_hi_c ^ POL;
      seg <= seg_hi_c ^ POL;
      led <= {OF, ZF};
    end
  end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Randomized self-checking bench for seg7_scan_display with a cycle-count based
// reference model (digit = (cycles since reset / SCAN_DIV) mod 8).
module tb_seg7_scan_display;

  localparam int unsigned SD = 4;

  logic        clk_100MHz = 1'b0;
  logic        rst;
  logic [31:0] F, M_R_Data, PC;
  logic        ZF, OF, freeze;
  logic [1:0]  sel;
  logic [7:0]  an, seg;
  logic [1:0]  led;

  int          n_vec = 0;
  int          n_err = 0;
  int          m_k;
  int          cur_d;
  logic [31:0] m_disp;
  logic [7:0]  e_an, e_seg;
  logic [1:0]  e_led;
  logic [6:0]  hex_tbl [16];

  always #5 clk_100MHz = ~clk_100MHz;

  seg7_scan_display #(.SCAN_DIV(SD), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk_100MHz(clk_100MHz), .rst(rst), .F(F), .M_R_Data(M_R_Data), .PC(PC),
    .ZF(ZF), .OF(OF), .sel(sel), .freeze(freeze), .an(an), .seg(seg), .led(led)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: model predicts outputs from pre-edge state, then compare.
  task automatic step();
    int         dd;
    logic       blank;
    logic [7:0] an_h, seg_h;
    @(posedge clk_100MHz);
    if (rst) begin
      e_an = 8'hFF; e_seg = 8'hFF; e_led = 2'b00;
      m_k = 0; m_disp = 32'd0; cur_d = 0;
    end else begin
      dd = (m_k / SD) % 8;
      cur_d = dd;
      blank = 1'b0;
`ifdef LZ_BLANK_EN
      blank = (dd > 0) && ((m_disp >> (4 * dd)) == 32'd0);
`endif
      an_h  = blank ? 8'h00 : 8'(1 << dd);
      seg_h = blank ? 8'h00 : {freeze && (dd == 0), hex_tbl[4'(m_disp >> (4 * dd))]};
      e_an = ~an_h; e_seg = ~seg_h; e_led = {OF, ZF};
      m_k++;
      if (!freeze) begin
        case (sel)
          2'd0: m_disp = F;
          2'd1: m_disp = M_R_Data;
          2'd2: m_disp = PC;
          default: m_disp = {30'd0, OF, ZF};
        endcase
      end
    end
    #1;
    chk("an", 32'(an), 32'(e_an));
    chk("seg", 32'(seg), 32'(e_seg));
    chk("led", 32'(led), 32'(e_led));
  endtask

  initial begin
    hex_tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    rst = 1'b1; F = 32'd0; M_R_Data = 32'd0; PC = 32'd0;
    ZF = 1'b0; OF = 1'b0; sel = 2'b00; freeze = 1'b0;

    // Reset values, then first post-reset cycle with all sources zero.
    repeat (3) step();
    chk("rst_an", 32'(an), 32'h FF);
    chk("rst_seg", 32'(seg), 32'h FF);
    rst = 1'b0;
    step();
    chk("rel_an", 32'(an), 32'h FE);
    chk("rel_seg", 32'(seg), 32'h C0);

    // Scan of F = 1234ABCD.
    rst = 1'b1; F = 32'h1234ABCD;
    step();
    rst = 1'b0;
    for (int k = 0; k <= 8 * SD; k++) begin
      step();
      if (k == 1) begin chk("scan_d0_an", 32'(an), 32'hFE); chk("scan_d0_seg", 32'(seg), 32'hA1); end
      if (k == 7 * SD + 1) begin chk("scan_d7_an", 32'(an), 32'h7F); chk("scan_d7_seg", 32'(seg), 32'hF9); end
      if (k == 8 * SD) chk("scan_wrap_an", 32'(an), 32'hFE);
    end

    // Freeze holds PC=40 while PC changes to 44.
    sel = 2'b10; PC = 32'h40;
    repeat (2) step();
    freeze = 1'b1; PC = 32'h44;
    for (int i = 0; i < 8 * SD; i++) begin
      step();
      if (cur_d == 1) chk("frz_d1", 32'(seg), 32'h99);
      if (cur_d == 0) chk("frz_d0_dp", 32'(seg), 32'h40);
    end
    freeze = 1'b0;
    for (int i = 0; i < 8 * SD; i++) begin
      step();
      if (cur_d == 0 && i >= SD) chk("unfrz_d0", 32'(seg), 32'h99);
    end

    // Flag LEDs, including while frozen.
    ZF = 1'b1; OF = 1'b0; step(); chk("led_zf", 32'(led), 32'h1);
    OF = 1'b1; step(); chk("led_of", 32'(led), 32'h3);
    freeze = 1'b1; ZF = 1'b0; step(); chk("led_frz", 32'(led), 32'h2);
    freeze = 1'b0;

    // Reset while digit 5 is lit; restart gives digit 0 a full slot.
    sel = 2'b00; F = 32'h1234ABCD;
    for (int i = 0; i < 16 * SD && cur_d != 5; i++) step();
    chk("reach_d5", 32'(cur_d), 32'd5);
    rst = 1'b1; step(); chk("mid_rst_an", 32'(an), 32'hFF);
    rst = 1'b0;
    for (int i = 0; i < SD; i++) begin step(); chk("restart_d0", 32'(an), 32'hFE); end
    step(); chk("restart_d1", 32'(an), 32'hFD);

    // Small values exercise leading zeros (blanked only with LZ_BLANK_EN).
    F = 32'h40;
    repeat (8 * SD + 2) step();
    F = 32'h0;
    repeat (8 * SD + 2) step();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) F = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 9) == 0) M_R_Data = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 9) == 0) PC = $urandom >> $urandom_range(0, 31);
      ZF = 1'($urandom); OF = 1'($urandom);
      if ($urandom_range(0, 19) == 0) sel = 2'($urandom);
      if ($urandom_range(0, 39) == 0) freeze = ~freeze;
      rst = ($urandom_range(0, 299) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
